updn_btn_ctrl: RTL
==================

Name: updn_btn_ctrl

Overview:
- Front-end stage that drives the 5-bit up/down counter's command inputs (IN, Load, Up, Down) from raw push-buttons and a 5-bit switch bank.
- Synchronises and debounces each button and converts presses into single-cycle command pulses, with optional hold-to-repeat.
- Uses the counter's High/Low flags as feedback to suppress pulses that would only be ignored at saturation.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (>=2)
- REPEAT_DELAY, 16, cycles a button must stay held after its first pulse before auto-repeat starts
- REPEAT_RATE, 4, cycles between auto-repeat pulses (>=1)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- btn_up  input  1  raw, asynchronous up button, active high
- btn_dn  input  1  raw, asynchronous down button, active high
- btn_load  input  1  raw, asynchronous load button, active high
- sw_in  input  5  raw switch value to be loaded
- High  input  1  counter at 5'b11111, from counter
- Low  input  1  counter at 5'b00000, from counter
- IN  output  5  registered load value, to counter
- Load  output  1  one-cycle load pulse
- Up  output  1  one-cycle increment pulse
- Down  output  1  one-cycle decrement pulse

Behaviour:
- Clocking and reset: one clock, clk. Asynchronous active-low reset rst_n. While reset is low, every flop clears: IN=0, Load=Up=Down=0, synchroniser and debounced levels=0, all FSMs=IDLE, all counters=0.
- Input capture: each raw button and each sw_in bit passes through a 2-flop synchroniser.
- Debounce, per button:
  - Counter increments each cycle while the synchronised level differs from the debounced level; clears when they match.
  - When the counter is at DEB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
- Latency: a raw level held stable from sampling edge 1 flips the debounced level at edge 2+DEB_CYCLES. The first pulse is registered at edge 3+DEB_CYCLES (7 with defaults).
- Up and Down each have a 3-state FSM:
  - IDLE: on debounced rising edge, request a pulse, load the hold counter with REPEAT_DELAY, go to HELD.
  - HELD: decrement the hold counter; on reaching 0, request a pulse, load REPEAT_RATE, go to REPEAT. On debounced release, go to IDLE.
  - REPEAT: decrement; on reaching 0, request a pulse and reload REPEAT_RATE. On release, go to IDLE.
- Load button: its debounced rising edge requests a load. No repeat.
- Output arbitration, registered, at most one pulse per cycle:
  - Priority: Load > Down > Up.
  - Losing requests are dropped, not queued. FSM timing continues unchanged.
- Saturation: an Up request is dropped if High=1 in the requesting cycle; a Down request is dropped if Low=1. Load is never suppressed.
- IN update: IN takes the synchronised sw_in on the same edge that raises Load, so IN is valid whenever Load=1. IN holds its value otherwise.
- Pulse width: every output pulse is exactly 1 cycle. A held button without repeat gives exactly one pulse per press.
- Reset mid-press: state restarts at IDLE with debounced level 0. A button still held after reset release is treated as a new press: debounce, then pulse.
- Glitch rejection: a synchronised glitch shorter than DEB_CYCLES cycles produces no pulse.

Optional Feature:
- Macro: UPDN_AUTO_REPEAT_EN.
- Defined: the HELD/REPEAT timing above is active.
- Undefined: HELD waits for release only, so there is one pulse per press. The REPEAT state and hold counter are not built, and REPEAT_DELAY and REPEAT_RATE are unused.

Decomposition:
- Shared package/include updn_pkg:
  - FSM state encodings IDLE=2'd0, HELD=2'd1, REPEAT=2'd2
  - Counter width constant CNT_W=5
  - Default parameter values
- Sub-module btn_debounce (2-flop synchroniser plus debounce counter, parameter DEB_CYCLES): instantiated three times, once per button.
- The sw_in synchroniser stays in the top level.

Test Plan:
- Reset, then btn_up held high from edge 1 (DEB_CYCLES=4): Up=1 only in the cycle after edge 7. No further Up with the macro undefined.
- UPDN_AUTO_REPEAT_EN defined, btn_up held 40 cycles: first Up at edge 7, second 16 cycles later, then one every 4 cycles until release. No Up after release.
- btn_up pulsed high for 3 cycles: no Up pulse. Debounced level stays 0.
- btn_load and btn_up pressed on the same edge, sw_in=5'b10110: Load=1 with IN=5'b10110. Up is not pulsed for that press.
- High=1 with btn_up pressed: no Up pulse. Low=1 with btn_dn pressed: no Down pulse. Low=0 with btn_dn pressed: Down pulses normally.
- rst_n asserted while in REPEAT with btn_dn held: outputs go to 0 immediately. After release of rst_n, the first Down comes DEB_CYCLES+3 edges later.

Source files
------------

// File: rtl/updn_pkg.sv
// Shared types and constants for the up/down counter button front-end.
// State encodings, widths, default timing and the output arbiter.
package updn_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } state_e;

   localparam int CNT_W = 5;

   localparam int DEF_DEB_CYCLES   = 4;
   localparam int DEF_REPEAT_DELAY = 16;
   localparam int DEF_REPEAT_RATE  = 4;

   localparam int BI_UP = 0;
   localparam int BI_DN = 1;
   localparam int BI_LD = 2;

   typedef struct packed {
      logic ld;
      logic dn;
      logic up;
   } req_t;

   // Saturated requests are removed before priority, so a blocked
   // Down does not shadow a valid Up in the same cycle.
   function automatic req_t arbitrate(req_t r, logic high, logic low);
      req_t g;
      g = '0;
      priority case (1'b1)
         r.ld:            g.ld = 1'b1;
         (r.dn && !low):  g.dn = 1'b1;
         (r.up && !high): g.up = 1'b1;
         default:         g = '0;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/updn_btn_ctrl_if.sv
// Button/switch inputs and counter command bus of the front-end.
// master = controller side, slave = counter/stimulus side.
interface updn_btn_ctrl_if;

   logic                       btn_up;
   logic                       btn_dn;
   logic                       btn_load;
   logic [updn_pkg::CNT_W-1:0] sw_in;
   logic                       High;
   logic                       Low;
   logic [updn_pkg::CNT_W-1:0] IN;
   logic                       Load;
   logic                       Up;
   logic                       Down;

   modport master (
      input  btn_up, btn_dn, btn_load, sw_in, High, Low,
      output IN, Load, Up, Down
   );

   modport slave (
      output btn_up, btn_dn, btn_load, sw_in, High, Low,
      input  IN, Load, Up, Down
   );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer.
// The level flips after DEB_CYCLES consecutive differing samples.
module btn_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level
);

   localparam int DW = $clog2(DEB_CYCLES);
   localparam logic [DW-1:0] LAST = DW'(DEB_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_lvl;
   logic [DW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_lvl <= 1'b0;
         r_cnt <= '0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         if (r_s2 == r_lvl) begin
            r_cnt <= '0;
         end else if (r_cnt == LAST) begin
            r_lvl <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign o_level = r_lvl;

endmodule

// File: rtl/updn_btn_ctrl.sv
// Button front-end: debounced presses become Load/Up/Down pulses.
// Hold-to-repeat is built only when UPDN_AUTO_REPEAT_EN is defined.
module updn_btn_ctrl
   import updn_pkg::*;
#(
   parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
   parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
   input logic             clk,
   input logic             rst_n,
   updn_btn_ctrl_if.master bus
);

   logic [2:0]       w_lvl;
   logic [1:0]       w_fire;
   req_t             w_req;
   req_t             w_arb;

   logic [CNT_W-1:0] r_sw1;
   logic [CNT_W-1:0] r_sw2;
   logic             r_ld_prev;
   state_e           r_state [2];
   logic [CNT_W-1:0] r_in;
   logic             r_load;
   logic             r_up;
   logic             r_dn;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_up),
      .o_level (w_lvl[BI_UP])
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_dn),
      .o_level (w_lvl[BI_DN])
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ld (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_load),
      .o_level (w_lvl[BI_LD])
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw1     <= '0;
         r_sw2     <= '0;
         r_ld_prev <= 1'b0;
      end else begin
         r_sw1     <= bus.sw_in;
         r_sw2     <= r_sw1;
         r_ld_prev <= w_lvl[BI_LD];
      end
   end

`ifdef UPDN_AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] DLY  = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE = CNT_W'(REPEAT_RATE);

   logic [CNT_W-1:0] r_hold [2];

   // Hold counter fires on the edge where it would reach zero.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_fire[c] = 1'b0;
         unique case (r_state[c])
            IDLE:         w_fire[c] = w_lvl[c];
            HELD, REPEAT: w_fire[c] = w_lvl[c] &&
                                      (r_hold[c] == CNT_W'(1));
            default:      w_fire[c] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            r_state[c] <= IDLE;
            r_hold[c]  <= '0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            unique case (r_state[c])
               IDLE: begin
                  if (w_lvl[c]) begin
                     r_state[c] <= HELD;
                     r_hold[c]  <= DLY;
                  end
               end
               HELD, REPEAT: begin
                  if (!w_lvl[c]) begin
                     r_state[c] <= IDLE;
                  end else if (r_hold[c] == CNT_W'(1)) begin
                     r_state[c] <= REPEAT;
                     r_hold[c]  <= RATE;
                  end else begin
                     r_hold[c]  <= r_hold[c] - 1'b1;
                  end
               end
               default: r_state[c] <= IDLE;
            endcase
         end
      end
   end
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);

   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_fire[c] = 1'b0;
         unique case (r_state[c])
            IDLE:    w_fire[c] = w_lvl[c];
            default: w_fire[c] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < 2; c++) begin
            r_state[c] <= IDLE;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            unique case (r_state[c])
               IDLE: begin
                  if (w_lvl[c]) r_state[c] <= HELD;
               end
               HELD, REPEAT: begin
                  if (!w_lvl[c]) r_state[c] <= IDLE;
               end
               default: r_state[c] <= IDLE;
            endcase
         end
      end
   end
`endif

   always_comb begin
      w_req    = '0;
      w_req.ld = w_lvl[BI_LD] & ~r_ld_prev;
      w_req.dn = w_fire[BI_DN];
      w_req.up = w_fire[BI_UP];
   end

   assign w_arb = arbitrate(w_req, bus.High, bus.Low);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in   <= '0;
         r_load <= 1'b0;
         r_up   <= 1'b0;
         r_dn   <= 1'b0;
      end else begin
         r_load <= w_arb.ld;
         r_up   <= w_arb.up;
         r_dn   <= w_arb.dn;
         if (w_arb.ld) r_in <= r_sw2;
      end
   end

   assign bus.IN   = r_in;
   assign bus.Load = r_load;
   assign bus.Up   = r_up;
   assign bus.Down = r_dn;

endmodule
